// File: rtl/debounce_multi_if.sv
// Bundles the sample tick, the raw button inputs and the debounced level / edge
// outputs of debounce_multi into a single interface.
// The master modport is used by whoever drives the buttons and the tick.
// The slave modport is used by the debouncer itself.
interface debounce_multi_if #(
    parameter int CHANNELS = 3
);
    logic                tick;
    logic [CHANNELS-1:0] button;
    logic [CHANNELS-1:0] debounced;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    modport master (
        output tick,
        output button,
        input  debounced,
        input  rise,
        input  fall
    );

    modport slave (
        input  tick,
        input  button,
        output debounced,
        output rise,
        output fall
    );
endinterface : debounce_multi_if

// File: rtl/debounce_multi.sv
// Multi-channel push-button / switch debouncer.
//
// Each raw input passes through a two-flop synchroniser. A per-channel counter
// then qualifies the synchronised level. The counter advances only on clock
// edges where tick is high. The output flips after STABLE_CYCLES consecutive
// tick-qualified samples that all differ from the current output. Any single
// sample that agrees with the output discards the accumulated count.
//
// Optional feature, selected by the macro DEBOUNCE_EDGE_EN:
//   defined   : registered single-cycle rise/fall pulses, aligned with the
//               edge on which debounced changes.
//   undefined : rise/fall are tied to 0 and no edge registers exist.
module debounce_multi #(
    parameter int CHANNELS      = 3,
    parameter int STABLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,   // asynchronous, active-low
    debounce_multi_if.slave  bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    // Terminal count: the sample that would make the run STABLE_CYCLES long.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] deb_q;
    logic [CHANNELS-1:0] deb_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];

    // Two-flop synchroniser; runs every clock, independent of tick.
    // NOTE: sequential state uses non-blocking (<=) so that sync2_q takes the
    // old value of sync1_q. A blocking assignment would collapse the two
    // stages into one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.button;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel stability counter and level decision (next state).
    // NOTE: every output of this block is defaulted to its held value first.
    // That makes the "tick low" path complete and infers no latches.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.tick) begin
                if (sync2_q[i] == deb_q[i]) begin
                    // Agreement wipes any partial run of disagreeing samples.
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    // Run is complete: accept the new level and restart.
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Counter and debounced-level registers.
    // NOTE: the counter array is small control state, so it is reset
    // explicitly. A mid-count reset must discard partial progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.debounced = deb_q;

`ifdef DEBOUNCE_EDGE_EN
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_d;

    // Edge detection on the pending level change.
    // The pulses land on the same edge as debounced and drop on the next one.
    assign rise_d =  deb_d & ~deb_q;
    assign fall_d = ~deb_d &  deb_q;

    // Edge pulse registers; updated every clock so a pulse never outlives one
    // cycle, even while tick is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
`else
    // Edge outputs kept in the port list but unused in this build.
    assign bus.rise = '0;
    assign bus.fall = '0;
`endif

endmodule : debounce_multi

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi.
//
// Two instances share the same stimulus: one with STABLE_CYCLES = 8 and one
// with STABLE_CYCLES = 4. A behavioural model tracks, per channel, the tick
// index of the last sample that agreed with the output. The output flips once
// STABLE_CYCLES tick samples in a row have disagreed with it.
// Edges are labelled E0, E1, ... with E0 the first rising edge after the
// input change (or after reset release).
module tb_debounce_multi;

    localparam int CH = 3;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          tick   = 1'b1;
    logic [CH-1:0] button = 3'b111;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_multi_if #(.CHANNELS(CH)) bus8 ();
    debounce_multi_if #(.CHANNELS(CH)) bus4 ();

    assign bus8.tick   = tick;
    assign bus8.button = button;
    assign bus4.tick   = tick;
    assign bus4.button = button;

    debounce_multi #(.CHANNELS(CH), .STABLE_CYCLES(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    debounce_multi #(.CHANNELS(CH), .STABLE_CYCLES(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    localparam int S_TAB [2] = '{8, 4};

    logic [CH-1:0] m_s1, m_s2;
    int unsigned   m_ticks;
    logic [CH-1:0] m_deb  [2];
    logic [CH-1:0] m_rise [2];
    logic [CH-1:0] m_fall [2];
    int unsigned   m_last [2][CH];

    initial begin
        m_s1 = '0; m_s2 = '0; m_ticks = 0;
        for (int m = 0; m < 2; m++) begin
            m_deb[m] = '0; m_rise[m] = '0; m_fall[m] = '0;
            for (int c = 0; c < CH; c++) m_last[m][c] = 0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_ticks = 0;
            for (int m = 0; m < 2; m++) begin
                m_deb[m] = '0; m_rise[m] = '0; m_fall[m] = '0;
                for (int c = 0; c < CH; c++) m_last[m][c] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                m_rise[m] = '0;
                m_fall[m] = '0;
            end
            if (tick) begin
                m_ticks++;
                for (int m = 0; m < 2; m++) begin
                    for (int c = 0; c < CH; c++) begin
                        if (m_s2[c] == m_deb[m][c]) begin
                            m_last[m][c] = m_ticks;
                        end else if (m_ticks - m_last[m][c] >= S_TAB[m]) begin
                            m_deb[m][c]  = m_s2[c];
                            m_rise[m][c] = m_s2[c];
                            m_fall[m][c] = ~m_s2[c];
                            m_last[m][c] = m_ticks;
                        end
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = button;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(posedge clk) begin
        #2;
        check("deb8",  bus8.debounced, m_deb[0]);
        check("rise8", bus8.rise, EDGE_EN ? m_rise[0] : 3'b000);
        check("fall8", bus8.fall, EDGE_EN ? m_fall[0] : 3'b000);
        check("deb4",  bus4.debounced, m_deb[1]);
        check("rise4", bus4.rise, EDGE_EN ? m_rise[1] : 3'b000);
        check("fall4", bus4.fall, EDGE_EN ? m_fall[1] : 3'b000);
    end

    task automatic settle(input logic [CH-1:0] val, input int n);
        @(negedge clk);
        button = val;
        tick   = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed scenarios + random phase ----------------
    initial begin
        // Reset held with all buttons high: all outputs must be 0.
        repeat (3) @(negedge clk);
        check("rst_deb8", bus8.debounced, 3'b000);
        check("rst_rise8", bus8.rise, 3'b000);
        check("rst_fall8", bus8.fall, 3'b000);
        check("rst_deb4", bus4.debounced, 3'b000);

        // Release: first edge after release is E0; S=8 flips at E9, S=4 at E5.
        reset = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #3;
            if (k == 4) check("lat4_E4", bus4.debounced, 3'b000);
            if (k == 5) check("lat4_E5", bus4.debounced, 3'b111);
            if (k == 8) check("lat8_E8", bus8.debounced, 3'b000);
            if (k == 9) begin
                check("lat8_E9", bus8.debounced, 3'b111);
                check("rise8_E9", bus8.rise, EDGE_EN ? 3'b111 : 3'b000);
            end
            if (k == 10) check("rise8_E10", bus8.rise, 3'b000);
        end

        // Glitch reject: channel 0 high for 7 clocks, then low.
        settle(3'b000, 20);
        button = 3'b001;
        repeat (7) @(negedge clk);
        button = 3'b000;
        repeat (12) @(negedge clk);
        check("glitch_deb8", bus8.debounced, 3'b000);

        // Bounce: channel 1 toggles every 3 clocks for 30 clocks, then low 20.
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) button[1] = ~button[1];
            @(negedge clk);
        end
        button[1] = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce_deb8", bus8.debounced, 3'b000);
        check("bounce_deb4", bus4.debounced, 3'b000);
        // A subsequent stable high gives rise[1] at E9.
        button[1] = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk); #3;
            if (k == 8) check("settle_E8", bus8.debounced, 3'b000);
            if (k == 9) begin
                check("settle_E9", bus8.debounced, 3'b010);
                check("settle_rise", bus8.rise, EDGE_EN ? 3'b010 : 3'b000);
            end
        end

        // Tick gating: tick on every 4th clock (E3, E7, E11, ...).
        // Channel 2 is stepped high before E0; S=4 flips at E15.
        settle(3'b000, 20);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            tick = (c % 4 == 3);
            if (c == 0)  button[2] = 1'b1;
            if (c == 20) button[2] = 1'b0;   // sync2 low from E22: fall at E35
            @(posedge clk); #3;
            if (c == 14) check("gate_E14", {2'b00, bus4.debounced[2]}, 3'b000);
            if (c == 15) check("gate_E15", {2'b00, bus4.debounced[2]}, 3'b001);
            if (c == 34) check("gate_E34", {2'b00, bus4.debounced[2]}, 3'b001);
            if (c == 35) begin
                check("gate_E35", {2'b00, bus4.debounced[2]}, 3'b000);
                check("gate_fall", bus4.fall, EDGE_EN ? 3'b100 : 3'b000);
            end
        end

        // Mid-count reset: channel 0 high 5 clocks, then a 1-clock reset.
        settle(3'b000, 60);
        button = 3'b001;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(posedge clk); #3;
            if (k == 8) check("mid_rst_E8", bus8.debounced, 3'b000);
            if (k == 9) check("mid_rst_E9", bus8.debounced, 3'b001);
        end

        // Randomised phase: alternating noisy and quiet stretches, random
        // tick, and an occasional reset pulse.
        begin
            int noisy;
            noisy = 0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (c % 64 == 0) noisy = int'($urandom_range(0, 1));
                reset = ($urandom_range(0, 599) != 0);
                tick  = ($urandom_range(0, 3) != 0);
                for (int b = 0; b < CH; b++) begin
                    if (noisy != 0) begin
                        if ($urandom_range(0, 4) == 0) button[b] = ~button[b];
                    end else begin
                        if ($urandom_range(0, 39) == 0) button[b] = ~button[b];
                    end
                end
            end
        end

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_debounce_multi
